// File: rtl/pe_acc_pkg.sv
// Shared types and helpers for the PE column output accumulator.
// Holds the control state encoding and a reference requantize.
package pe_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  localparam int SHIFT_W = 6;
  localparam int ACC_W   = 40;
  localparam int OUT_W   = 16;

  // Round half up, arithmetic shift, saturate at the default widths.
  function automatic logic signed [OUT_W-1:0] requantize(
    input logic signed [ACC_W-1:0]   acc,
    input logic        [SHIFT_W-1:0] sh
  );
    logic signed [ACC_W:0] e;
    logic signed [ACC_W:0] b;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] hi;
    e  = (ACC_W+1)'(acc);
    b  = (ACC_W+1)'(1) << (sh - SHIFT_W'(1));
    r  = (sh == '0) ? e : ((e + b) >>> sh);
    hi = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    if (r > hi)
      r = hi;
    else if (r < ~hi)
      r = ~hi;
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/acc_requantize.sv
// Combinational round / arithmetic shift / saturate of one
// accumulator entry; the parent registers the result.
module acc_requantize
  import pe_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic signed [OUT_WIDTH-1:0] q
);

  localparam logic signed [ACC_WIDTH:0] MAXV =
    (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  logic signed [ACC_WIDTH:0] ext;
  logic signed [ACC_WIDTH:0] bias;
  logic signed [ACC_WIDTH:0] shd;
  logic signed [ACC_WIDTH:0] sat;

  // One extra bit keeps the rounding add from overflowing.
  always_comb begin
    ext  = (ACC_WIDTH+1)'(acc);
    bias = (ACC_WIDTH+1)'(1) << (shift - SHIFT_W'(1));
    shd  = (shift == '0) ? ext : ((ext + bias) >>> shift);
    sat  = shd;
    if (shd > MAXV)
      sat = MAXV;
    else if (shd < MINV)
      sat = MINV;
    q = sat[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/pe_output_accumulator.sv
// Accumulates PE column results over K-tile passes, then
// requantizes and drains them over a valid/ready stream.
module pe_output_accumulator
  import pe_acc_pkg::*;
#(
  parameter int PE_OUT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40,
  parameter int OUT_WIDTH    = 16,
  parameter int DEPTH        = 16,
  parameter int PASS_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(DEPTH):0]      cfg_num_words,
  input  logic [PASS_WIDTH-1:0]       cfg_num_passes,
  input  logic [5:0]                  cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PE_OUT_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, didx_q, rd_idx;
  logic [PASS_WIDTH-1:0]         pass_q, np_q;
  logic [CW-1:0]                 nw_q;
  logic [5:0]                    shift_q;
  logic signed [ACC_WIDTH-1:0]   acc_q [DEPTH];
  logic signed [ACC_WIDTH-1:0]   in_ext, wr_val, rd_val;
  logic signed [OUT_WIDTH-1:0]   rq;
  logic accept, last_word, last_pass, out_hs, drain_last, load_out;

  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign last_word  = ({1'b0, idx_q} == nw_q - CW'(1));
  assign last_pass  = (pass_q == np_q - PASS_WIDTH'(1));
  assign drain_last = ({1'b0, didx_q} == nw_q - CW'(1));
  assign busy       = (state_q != IDLE);

  assign in_ext = ACC_WIDTH'(in_data);
  assign wr_val = (pass_q == '0) ? in_ext : acc_q[idx_q] + in_ext;

  // Forward the entry being written so a one-word tile drains fresh data.
  assign rd_idx = (state_q == DRAIN) ? didx_q + IW'(1) : '0;
  assign rd_val = (accept && idx_q == rd_idx) ? wr_val : acc_q[rd_idx];

  acc_requantize #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rq (
    .acc  (rd_val),
    .shift(shift_q),
    .q    (rq)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_word && last_pass) begin
          state_d  = DRAIN;
          load_out = 1'b1;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (drain_last) state_d = IDLE;
          else            load_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      pass_q    <= '0;
      didx_q    <= '0;
      nw_q      <= '0;
      np_q      <= '0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE && start) begin
        nw_q    <= cfg_num_words;
        np_q    <= cfg_num_passes;
        shift_q <= cfg_shift;
        idx_q   <= '0;
        pass_q  <= '0;
        didx_q  <= '0;
      end
      if (accept) begin
        if (last_word) begin
          idx_q  <= '0;
          pass_q <= pass_q + PASS_WIDTH'(1);
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
      if (state_q == DRAIN && out_hs) begin
        if (drain_last) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
          didx_q    <= '0;
        end else begin
          didx_q <= didx_q + IW'(1);
        end
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= rq;
      end
    end
  end

  // Partial-sum buffer: no reset, pass 0 overwrites every entry.
  always_ff @(posedge clk) begin
    if (accept) acc_q[idx_q] <= wr_val;
  end

endmodule

// File: tb/tb_pe_output_accumulator.sv
// Scoreboard bench for pe_output_accumulator: expected outputs
// are queued at stimulus time and popped on each out handshake.
module tb_pe_output_accumulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [4:0]         cfg_num_words;
  logic [7:0]         cfg_num_passes;
  logic [5:0]         cfg_shift;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;
  longint sb[$];
  int rdy_mode = 0;

  always #5 clk = ~clk;

  pe_output_accumulator dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_num_words (cfg_num_words),
    .cfg_num_passes(cfg_num_passes),
    .cfg_shift     (cfg_shift),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint rq_model(input longint a, input int sh);
    longint r;
    if (sh == 0) r = a;
    else r = (a + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // out_ready pattern 1,0,0,1 in backpressure mode
  initial begin
    int c = 0;
    bit [3:0] pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else out_ready = pat[c % 4];
      c++;
    end
  end

  // Output monitor: scoreboard pop and stall stability.
  initial begin
    bit stall_prev = 0;
    longint held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("extra_out", 1, 0);
          else chk("out_data", out_data, sb.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  task automatic send(input int d, input bit gaps, input bit poke);
    int to = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = d;
    if (poke) begin
      start = 1'b1;
      cfg_num_words = 5'd1;
      cfg_num_passes = 8'd1;
      cfg_shift = 6'd5;
    end
    forever begin
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      to++;
      if (to > 50) begin
        chk("in_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int nw, input int np, input int sh);
    start = 1'b1;
    cfg_num_words = 5'(nw);
    cfg_num_passes = 8'(np);
    cfg_shift = 6'(sh);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
  endtask

  task automatic run_tile(input int nw, input int np, input int sh,
                          input int d[$], input bit gaps, input bit poke,
                          input bit timing);
    logic signed [39:0] acc [16];
    int cyc = 0;
    for (int p = 0; p < np; p++)
      for (int w = 0; w < nw; w++) begin
        logic signed [39:0] x;
        x = 40'(signed'(d[p*nw+w]));
        acc[w] = (p == 0) ? x : acc[w] + x;
      end
    for (int w = 0; w < nw; w++) sb.push_back(rq_model(longint'(acc[w]), sh));
    pulse_start(nw, np, sh);
    for (int k = 0; k < nw*np; k++) send(d[k], gaps, poke && k == 1);
    chk("ov_after_last", out_valid, 1);
    chk("in_ready_after_last", in_ready, 0);
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1);
    if (timing) chk("drain_cycles", cyc, nw);
    chk("busy_at_done", busy, 0);
    chk("ov_at_done", out_valid, 0);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int d[$];
    reset = 1'b1;
    start = 1'b0;
    cfg_num_words = '0;
    cfg_num_passes = '0;
    cfg_shift = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    d = '{1, -2, 3, -4};
    run_tile(4, 1, 0, d, 0, 0, 1);

    d = '{10, 20, 10, 20, 10, 20};
    run_tile(2, 3, 1, d, 0, 0, 1);

    d = '{5, -5, 7, -7};
    run_tile(4, 1, 1, d, 0, 0, 1);

    d = '{1 << 20, -(1 << 20), 1 << 19};
    run_tile(3, 1, 0, d, 0, 0, 1);
    d = '{1 << 19, -(1 << 19) - 16, 40, -24};
    run_tile(4, 1, 4, d, 0, 0, 1);

    d = '{};
    for (int k = 0; k < 8; k++) d.push_back($urandom_range(0, 200000) - 100000);
    rdy_mode = 1;
    run_tile(4, 2, 3, d, 0, 0, 0);
    rdy_mode = 0;

    d = '{};
    for (int k = 0; k < 16; k++) d.push_back($urandom_range(0, 60000) - 30000);
    run_tile(8, 2, 2, d, 1, 1, 0);

    // reset mid-ACCUM after three words
    pulse_start(4, 2, 0);
    for (int k = 0; k < 3; k++) send(1000 + k, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    d = '{7, 8, 9, 10, 1, 1, 1, 1};
    run_tile(4, 2, 0, d, 0, 0, 1);

    d = '{100, -30, 45};
    run_tile(1, 3, 1, d, 0, 0, 1);

    d = '{};
    for (int k = 0; k < 16; k++) d.push_back(int'($urandom()));
    run_tile(16, 1, 16, d, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
